// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and emits
// them one bit per clock on sout, with a one-word hold register so words stream gap-free.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;

  logic             accept;
  logic             last_bit;
  logic             load_from_hold;
  logic             load_from_in;
  logic             start_word;
  logic             shift_en;
  logic             hold_wr;
  logic [WIDTH-1:0] new_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // shreg keeps only the bits not yet on sout, so sout itself can be a flop.
  function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign load_ready = !hold_full;

  always_comb begin
    accept         = load_valid && !hold_full;
    last_bit       = (state == SHIFT) && (bit_cnt == LAST_IDX);
    load_from_hold = last_bit && hold_full;
    load_from_in   = accept && ((state == IDLE) || last_bit);
    start_word     = load_from_hold || load_from_in;
    shift_en       = (state == SHIFT) && !last_bit;
    hold_wr        = accept && shift_en;
    new_word       = load_from_hold ? hold : load_data;
  end

  // Data path: no reset needed, contents are qualified by the control state.
  always_ff @(posedge clk) begin
    if (start_word) begin
      shreg <= rest_bits(new_word);
    end else if (shift_en) begin
      shreg <= rest_bits(shreg);
    end
    if (hold_wr) begin
      hold <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      sout      <= IDLE_BIT;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (start_word) begin
        state     <= SHIFT;
        bit_cnt   <= '0;
        sout      <= first_bit(new_word);
        bit_valid <= 1'b1;
        word_done <= 1'b0;
        busy      <= 1'b1;
      end else if (shift_en) begin
        bit_cnt   <= bit_cnt + CNT_W'(1);
        sout      <= first_bit(shreg);
        bit_valid <= 1'b1;
        word_done <= (bit_cnt == PENULT_IDX);
        busy      <= 1'b1;
      end else begin
        // Idle, or the last bit finished with nothing queued behind it.
        state     <= IDLE;
        bit_cnt   <= '0;
        sout      <= IDLE_BIT;
        bit_valid <= 1'b0;
        word_done <= 1'b0;
        busy      <= 1'b0;
      end

      if (load_from_hold) begin
        hold_full <= 1'b0;
      end else if (hold_wr) begin
        hold_full <= 1'b1;
      end
    end
  end

endmodule
